// File: rtl/tri_setup_if.sv
// Triangle setup bus. The upstream gather side and the rasterizer side
// share one bundle; "slave" is the setup stage, "master" its environment.
interface tri_setup_if;
  logic        in_valid;
  logic        in_ack;
  logic [95:0] vertex_in0, vertex_in1, vertex_in2;
  logic [95:0] color_in0, color_in1, color_in2;

  logic        out_valid;
  logic        out_ready;
  logic [16:0] edge_a0, edge_a1, edge_a2;
  logic [16:0] edge_b0, edge_b1, edge_b2;
  logic [32:0] edge_c0, edge_c1, edge_c2;
  logic [33:0] area2;
  logic        flipped;
  logic [15:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic [31:0] z_out0, z_out1, z_out2;
  logic [95:0] color_out0, color_out1, color_out2;
  logic [15:0] drop_count;

  modport slave (
    input  in_valid, vertex_in0, vertex_in1, vertex_in2,
           color_in0, color_in1, color_in2, out_ready,
    output in_ack, out_valid,
           edge_a0, edge_a1, edge_a2, edge_b0, edge_b1, edge_b2,
           edge_c0, edge_c1, edge_c2, area2, flipped,
           bb_xmin, bb_xmax, bb_ymin, bb_ymax,
           z_out0, z_out1, z_out2, color_out0, color_out1, color_out2,
           drop_count
  );

  modport master (
    output in_valid, vertex_in0, vertex_in1, vertex_in2,
           color_in0, color_in1, color_in2, out_ready,
    input  in_ack, out_valid,
           edge_a0, edge_a1, edge_a2, edge_b0, edge_b1, edge_b2,
           edge_c0, edge_c1, edge_c2, area2, flipped,
           bb_xmin, bb_xmax, bb_ymin, bb_ymax,
           z_out0, z_out1, z_out2, color_out0, color_out1, color_out2,
           drop_count
  );
endinterface

// File: rtl/tri_setup.sv
// Triangle setup: serial edge-function evaluation (one edge per cycle),
// signed double area, clipped bounding box, cull/drop decision, and a
// valid/ready hand-off to raster traversal.

// Per-edge coefficient holder: loads during its EDGE slot, negates in
// place when the triangle turns out to be clockwise.
module tri_setup_edge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic        neg,
  input  logic [16:0] a_in,
  input  logic [16:0] b_in,
  input  logic [32:0] c_in,
  output logic [16:0] a,
  output logic [16:0] b,
  output logic [32:0] c
);
  // Load new coefficients, or flip their sign for winding normalisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else if (ld) begin
      a <= a_in;
      b <= b_in;
      c <= c_in;
    end else if (neg) begin
      a <= -a;
      b <= -b;
      c <= -c;
    end
  end
endmodule

module tri_setup #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int CULL_BACK = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  tri_setup_if.slave bus
);
  localparam logic [15:0] XLIM = 16'(SCREEN_W - 1);
  localparam logic [15:0] YLIM = 16'(SCREEN_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_EDGE, S_AREA, S_ORIENT, S_OUT} state_t;

  state_t state_q, state_d;

  logic [2:0][15:0] vx, vy;
  logic [2:0][31:0] vz;
  logic [2:0][95:0] col;
  logic [1:0]       eidx, jidx;

  logic [2:0][16:0] ea, eb;
  logic [2:0][32:0] ec;
  logic [33:0]      area2_q;
  logic [15:0]      xmin, xmax, ymin, ymax;
  logic [15:0]      drops;
  logic             ack_q, ovld_q, flip_q;

  logic [15:0] xi, xj, yi, yj;
  logic [31:0] p_ij, p_ji;
  logic [16:0] a_nx, b_nx;
  logic [32:0] c_nx;
  logic [33:0] area_sum;
  logic        drop_now, neg_en;

  function automatic logic [15:0] min3(input logic [15:0] p, q, r);
    logic [15:0] m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic logic [15:0] max3(input logic [15:0] p, q, r);
    logic [15:0] m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  // Edge i pairs vertex i with its successor j = (i+1) mod 3.
  assign jidx = (eidx == 2'd2) ? 2'd0 : eidx + 2'd1;
  assign xi   = vx[eidx];
  assign yi   = vy[eidx];
  assign xj   = vx[jidx];
  assign yj   = vy[jidx];
  assign p_ij = 32'(xi) * 32'(yj);
  assign p_ji = 32'(xj) * 32'(yi);
  // Zero-extended unsigned operands make every difference exact in one
  // extra bit, so no saturation is ever needed.
  assign a_nx = {1'b0, yi} - {1'b0, yj};
  assign b_nx = {1'b0, xj} - {1'b0, xi};
  assign c_nx = {1'b0, p_ij} - {1'b0, p_ji};

  assign area_sum = {ec[0][32], ec[0]} + {ec[1][32], ec[1]} + {ec[2][32], ec[2]};

  // Drop priority: degenerate, then off-screen, then back-face cull.
  assign drop_now = (area2_q == '0) || (xmin > XLIM) || (ymin > YLIM) ||
                    (area2_q[33] && (CULL_BACK != 0));
  assign neg_en   = (state_q == S_ORIENT) && !drop_now && area2_q[33];

  for (genvar g = 0; g < 3; g++) begin : g_edge
    tri_setup_edge u_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .ld   ((state_q == S_EDGE) && (eidx == 2'(g))),
      .neg  (neg_en),
      .a_in (a_nx),
      .b_in (b_nx),
      .c_in (c_nx),
      .a    (ea[g]),
      .b    (eb[g]),
      .c    (ec[g])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = S_EDGE;
      S_EDGE:   if (eidx == 2'd2) state_d = S_AREA;
      S_AREA:   state_d = S_ORIENT;
      S_ORIENT: state_d = drop_now ? S_IDLE : S_OUT;
      S_OUT:    if (bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Handshake flags, winding flag and drop counter. in_ack is registered
  // so it marks the edge on which the inputs were captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      ovld_q <= 1'b0;
      flip_q <= 1'b0;
      drops  <= '0;
    end else begin
      ack_q <= (state_q == S_IDLE) && bus.in_valid;
      if (state_q == S_ORIENT) begin
        if (drop_now) begin
          drops <= drops + 16'd1;
        end else begin
          ovld_q <= 1'b1;
          flip_q <= area2_q[33];
        end
      end else if ((state_q == S_OUT) && bus.out_ready) begin
        ovld_q <= 1'b0;
      end
    end
  end

  // Capture the triangle on acceptance and step the edge index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vx   <= '0;
      vy   <= '0;
      vz   <= '0;
      col  <= '0;
      eidx <= '0;
    end else if ((state_q == S_IDLE) && bus.in_valid) begin
      vx   <= {bus.vertex_in2[15:0],  bus.vertex_in1[15:0],  bus.vertex_in0[15:0]};
      vy   <= {bus.vertex_in2[47:32], bus.vertex_in1[47:32], bus.vertex_in0[47:32]};
      vz   <= {bus.vertex_in2[95:64], bus.vertex_in1[95:64], bus.vertex_in0[95:64]};
      col  <= {bus.color_in2, bus.color_in1, bus.color_in0};
      eidx <= 2'd0;
    end else if (state_q == S_EDGE) begin
      eidx <= eidx + 2'd1;
    end
  end

  // Area and clipped bounding box; area made non-negative on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      area2_q <= '0;
      xmin    <= '0;
      xmax    <= '0;
      ymin    <= '0;
      ymax    <= '0;
    end else if (state_q == S_AREA) begin
      area2_q <= area_sum;
      xmin    <= min3(vx[0], vx[1], vx[2]);
      ymin    <= min3(vy[0], vy[1], vy[2]);
      xmax    <= (max3(vx[0], vx[1], vx[2]) > XLIM) ? XLIM : max3(vx[0], vx[1], vx[2]);
      ymax    <= (max3(vy[0], vy[1], vy[2]) > YLIM) ? YLIM : max3(vy[0], vy[1], vy[2]);
    end else if (neg_en) begin
      area2_q <= -area2_q;
    end
  end

  assign bus.in_ack     = ack_q;
  assign bus.out_valid  = ovld_q;
  assign bus.flipped    = flip_q;
  assign bus.drop_count = drops;
  assign bus.area2      = area2_q;
  assign bus.edge_a0    = ea[0];
  assign bus.edge_a1    = ea[1];
  assign bus.edge_a2    = ea[2];
  assign bus.edge_b0    = eb[0];
  assign bus.edge_b1    = eb[1];
  assign bus.edge_b2    = eb[2];
  assign bus.edge_c0    = ec[0];
  assign bus.edge_c1    = ec[1];
  assign bus.edge_c2    = ec[2];
  assign bus.bb_xmin    = xmin;
  assign bus.bb_xmax    = xmax;
  assign bus.bb_ymin    = ymin;
  assign bus.bb_ymax    = ymax;
  assign bus.z_out0     = vz[0];
  assign bus.z_out1     = vz[1];
  assign bus.z_out2     = vz[2];
  assign bus.color_out0 = col[0];
  assign bus.color_out1 = col[1];
  assign bus.color_out2 = col[2];
endmodule

// File: tb/tb_tri_setup.sv
// Bench for tri_setup: two instances (CULL_BACK=0 and 1) fed identical
// stimulus; table vectors, hand sequences, then random triangles against
// a shoelace-formula reference model.
module tb_tri_setup;
  localparam int SW = 640;
  localparam int SH = 480;

  typedef struct packed {
    logic [2:0][15:0] x;
    logic [2:0][15:0] y;
    logic             v0;   // expected out_valid, no culling
    logic             v1;   // expected out_valid, back-face culling
    logic [2:0][31:0] a;
    logic [2:0][31:0] b;
    logic [2:0][63:0] c;
    logic [63:0]      area;
    logic             flip;
    logic [15:0]      xmn, xmx, ymn, ymx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, out_ready;
  logic [95:0] vin [3];
  logic [95:0] cin [3];

  logic        ack [2];
  logic        ov  [2];
  logic        flp [2];
  logic [16:0] ea  [2][3];
  logic [16:0] eb  [2][3];
  logic [32:0] ec  [2][3];
  logic [33:0] ar  [2];
  logic [15:0] bx0 [2];
  logic [15:0] bx1 [2];
  logic [15:0] by0 [2];
  logic [15:0] by1 [2];
  logic [15:0] dc  [2];
  logic [31:0] zo  [2][3];
  logic [95:0] co  [2][3];

  int n_chk = 0, n_pass = 0;
  int drops0 = 0, drops1 = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tri_setup_if bus ();
    tri_setup #(.SCREEN_W(SW), .SCREEN_H(SH), .CULL_BACK(g)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
    assign bus.in_valid   = in_valid;
    assign bus.out_ready  = out_ready;
    assign bus.vertex_in0 = vin[0];
    assign bus.vertex_in1 = vin[1];
    assign bus.vertex_in2 = vin[2];
    assign bus.color_in0  = cin[0];
    assign bus.color_in1  = cin[1];
    assign bus.color_in2  = cin[2];
    assign ack[g]   = bus.in_ack;
    assign ov[g]    = bus.out_valid;
    assign flp[g]   = bus.flipped;
    assign ea[g][0] = bus.edge_a0;
    assign ea[g][1] = bus.edge_a1;
    assign ea[g][2] = bus.edge_a2;
    assign eb[g][0] = bus.edge_b0;
    assign eb[g][1] = bus.edge_b1;
    assign eb[g][2] = bus.edge_b2;
    assign ec[g][0] = bus.edge_c0;
    assign ec[g][1] = bus.edge_c1;
    assign ec[g][2] = bus.edge_c2;
    assign ar[g]    = bus.area2;
    assign bx0[g]   = bus.bb_xmin;
    assign bx1[g]   = bus.bb_xmax;
    assign by0[g]   = bus.bb_ymin;
    assign by1[g]   = bus.bb_ymax;
    assign dc[g]    = bus.drop_count;
    assign zo[g][0] = bus.z_out0;
    assign zo[g][1] = bus.z_out1;
    assign zo[g][2] = bus.z_out2;
    assign co[g][0] = bus.color_out0;
    assign co[g][1] = bus.color_out1;
    assign co[g][2] = bus.color_out2;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chkw(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input int x0, y0, x1, y1, x2, y2,
                              input bit v0, v1,
                              input int a0, a1, a2, b0, b1, b2,
                              input longint c0, c1, c2, area,
                              input bit flip, input int xmn, xmx, ymn, ymx);
    vec_t m;
    m = '0;
    m.x[0] = 16'(x0); m.y[0] = 16'(y0);
    m.x[1] = 16'(x1); m.y[1] = 16'(y1);
    m.x[2] = 16'(x2); m.y[2] = 16'(y2);
    m.v0 = v0; m.v1 = v1;
    m.a[0] = 32'(a0); m.a[1] = 32'(a1); m.a[2] = 32'(a2);
    m.b[0] = 32'(b0); m.b[1] = 32'(b1); m.b[2] = 32'(b2);
    m.c[0] = 64'(c0); m.c[1] = 64'(c1); m.c[2] = 64'(c2);
    m.area = 64'(area); m.flip = flip;
    m.xmn = 16'(xmn); m.xmx = 16'(xmx); m.ymn = 16'(ymn); m.ymx = 16'(ymx);
    return m;
  endfunction

  // Reference: orientation from the shoelace cross product, edges from
  // their defining formulas, box from plain min/max and screen limits.
  function automatic vec_t model(input logic [2:0][15:0] xs, input logic [2:0][15:0] ys);
    vec_t m;
    longint x[3], y[3], area, s, mnx, mxx, mny, mxy;
    bit drop;
    m = '0;
    m.x = xs; m.y = ys;
    for (int i = 0; i < 3; i++) begin
      x[i] = longint'(xs[i]);
      y[i] = longint'(ys[i]);
    end
    area = (x[1] - x[0]) * (y[2] - y[0]) - (x[2] - x[0]) * (y[1] - y[0]);
    s = (area < 0) ? -1 : 1;
    for (int i = 0; i < 3; i++) begin
      int j;
      j = (i + 1) % 3;
      m.a[i] = 32'(s * (y[i] - y[j]));
      m.b[i] = 32'(s * (x[j] - x[i]));
      m.c[i] = 64'(s * (x[i] * y[j] - x[j] * y[i]));
    end
    mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
    for (int i = 1; i < 3; i++) begin
      if (x[i] < mnx) mnx = x[i];
      if (x[i] > mxx) mxx = x[i];
      if (y[i] < mny) mny = y[i];
      if (y[i] > mxy) mxy = y[i];
    end
    if (mxx > SW - 1) mxx = SW - 1;
    if (mxy > SH - 1) mxy = SH - 1;
    drop   = (area == 0) || (mnx > SW - 1) || (mny > SH - 1);
    m.v0   = !drop;
    m.v1   = !drop && (area > 0);
    m.area = 64'(s * area);
    m.flip = (area < 0);
    m.xmn = 16'(mnx); m.xmx = 16'(mxx); m.ymn = 16'(mny); m.ymx = 16'(mxy);
    return m;
  endfunction

  task automatic drive(input vec_t e);
    for (int i = 0; i < 3; i++) begin
      vin[i] = {32'($urandom()), 16'($urandom()), e.y[i], 16'($urandom()), e.x[i]};
      cin[i] = {32'($urandom()), 32'($urandom()), 32'($urandom())};
    end
  endtask

  // Raise in_valid and expect the registered ack after exactly one edge.
  task automatic wait_ack();
    int n;
    n = -1;
    in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack[0]) begin
        n = k;
        break;
      end
    end
    in_valid = 1'b0;
    chk("ack_latency", n, 1);
    if (n > 0) chk("ack_dut1", ack[1], 1);
  endtask

  task automatic chk_fields(input int d, input vec_t e);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("a%0d_d%0d", i, d), longint'($signed(ea[d][i])), longint'(int'(e.a[i])));
      chk($sformatf("b%0d_d%0d", i, d), longint'($signed(eb[d][i])), longint'(int'(e.b[i])));
      chk($sformatf("c%0d_d%0d", i, d), longint'($signed(ec[d][i])), longint'(e.c[i]));
      chk($sformatf("z%0d_d%0d", i, d), longint'(zo[d][i]), longint'(vin[i][95:64]));
      chkw($sformatf("col%0d_d%0d", i, d), co[d][i], cin[i]);
    end
    chk($sformatf("area2_d%0d", d), longint'({30'b0, ar[d]}), longint'(e.area));
    chk($sformatf("flipped_d%0d", d), longint'(flp[d]), longint'(e.flip));
    chk($sformatf("xmin_d%0d", d), longint'(bx0[d]), longint'(e.xmn));
    chk($sformatf("xmax_d%0d", d), longint'(bx1[d]), longint'(e.xmx));
    chk($sformatf("ymin_d%0d", d), longint'(by0[d]), longint'(e.ymn));
    chk($sformatf("ymax_d%0d", d), longint'(by1[d]), longint'(e.ymx));
  endtask

  // Called at the negedge after the accepting edge N; result due after N+5.
  task automatic wait_result(input vec_t e);
    repeat (4) @(negedge clk);
    chk("valid_early", ov[0], 0);
    @(negedge clk);
    if (!e.v0) drops0++;
    if (!e.v1) drops1++;
    chk("valid_d0", ov[0], e.v0);
    chk("valid_d1", ov[1], e.v1);
    if (e.v0) chk_fields(0, e);
    if (e.v1) chk_fields(1, e);
    chk("drop_count_d0", dc[0], 16'(drops0));
    chk("drop_count_d1", dc[1], 16'(drops1));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_clear", ov[0], 0);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t e;
    logic [2:0][15:0] xs, ys;
    logic [16:0] s_a;
    logic [32:0] s_c;
    logic [33:0] s_ar;
    logic [95:0] s_col;
    logic [15:0] s_bx;
    int bad;

    tbl[0] = mk(0, 0, 10, 0, 0, 10, 1, 1, 0, -10, 10, 10, -10, 0, 0, 100, 0, 100, 0, 0, 10, 0, 10);
    tbl[1] = mk(0, 0, 0, 10, 10, 0, 1, 0, 10, -10, 0, 0, -10, 10, 0, 100, 0, 100, 1, 0, 10, 0, 10);
    tbl[2] = mk(0, 0, 5, 5, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(640, 0, 700, 0, 640, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(0, 0, 700, 0, 0, 10, 1, 1, 0, -10, 10, 700, -700, 0, 0, 7000, 0, 7000, 0, 0, 639, 0, 10);
    tbl[5] = mk(5, 470, 20, 470, 5, 500, 1, 1, 0, -30, 30, 15, -15, 0, -7050, 7650, -150, 450, 0, 5, 20, 470, 479);

    // Reset held with a request pending: nothing may be acknowledged.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    drive(tbl[0]);
    repeat (2) @(negedge clk);
    chk("rst_ack_d0", ack[0], 0);
    chk("rst_ack_d1", ack[1], 0);
    chk("rst_valid", ov[0], 0);
    chk("rst_drop_count", dc[0], 0);
    chk("rst_area2", longint'(ar[0]), 0);
    chk("rst_flipped", flp[0], 0);
    rst_n = 1'b1;
    wait_ack();
    wait_result(tbl[0]);
    release_out();

    for (int k = 1; k < 6; k++) begin
      drive(tbl[k]);
      wait_ack();
      wait_result(tbl[k]);
      if (tbl[k].v0) release_out();
    end

    // Backpressure: output parked with a new request waiting.
    drive(tbl[0]);
    wait_ack();
    wait_result(tbl[0]);
    s_a = ea[0][1]; s_c = ec[0][1]; s_ar = ar[0]; s_col = co[0][2]; s_bx = bx1[0];
    in_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack[0] || !ov[0] || ea[0][1] != s_a || ec[0][1] != s_c ||
          ar[0] != s_ar || co[0][2] != s_col || bx1[0] != s_bx) bad++;
    end
    chk("bp_stable", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_valid_clear", ov[0], 0);
    chk("bp_no_same_cycle_ack", ack[0], 0);
    @(negedge clk);
    chk("bp_ack_next", ack[0], 1);
    in_valid = 1'b0;
    wait_result(tbl[0]);
    release_out();

    // Reset during EDGE: the in-flight (degenerate) triangle is lost.
    drive(tbl[2]);
    wait_ack();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", ov[0], 0);
    chk("midrst_drop_count", dc[0], 0);
    drops0 = 0;
    drops1 = 0;
    #1 rst_n = 1'b1;
    drive(tbl[5]);
    wait_ack();
    wait_result(tbl[5]);
    release_out();

    // Random triangles: wide, near-screen, tiny and collinear mixes.
    for (int r = 0; r < 48; r++) begin
      int mode, x0, y0, dx, dy;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 3; i++) begin
        case (mode)
          0:       begin xs[i] = 16'($urandom()); ys[i] = 16'($urandom()); end
          1:       begin xs[i] = 16'($urandom_range(0, 800)); ys[i] = 16'($urandom_range(0, 600)); end
          default: begin xs[i] = 16'($urandom_range(0, 15)); ys[i] = 16'($urandom_range(0, 15)); end
        endcase
      end
      if (mode == 3) begin
        x0 = $urandom_range(0, 1000); y0 = $urandom_range(0, 1000);
        dx = $urandom_range(0, 50);   dy = $urandom_range(0, 50);
        for (int i = 0; i < 3; i++) begin
          xs[i] = 16'(x0 + i * dx);
          ys[i] = 16'(y0 + i * dy);
        end
      end
      e = model(xs, ys);
      drive(e);
      wait_ack();
      wait_result(e);
      if (e.v0) release_out();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
